alut_age_checker: RTL and testbench
===================================

Name: alut_age_checker

Overview:
- Responder end of the ALUT age-check handshake.
- Takes `check_age` / `last_accessed` requests from the address checker and computes the entry age as `curr_time - last_accessed`, modulo 2^32.
- Compares the age against the software-programmed maximum age and returns `age_confirmed` / `age_ok`.
- Sits beside the address checker inside the ALUT, on the APB clock domain.

Parameters:
- TIME_W, 32, width of timestamps, ages and the maximum-age threshold.

Ports:
- pclk  input  1  APB clock.
- p_reset  input  1  reset, synchronous, active-high.
- check_age  input  1  request strobe from the address checker; may re-pulse every other cycle while that checker waits.
- last_accessed  input  TIME_W  stored entry timestamp; valid in the cycle check_age=1.
- curr_time  input  TIME_W  free-running time counter.
- max_age  input  TIME_W  programmed age limit; 0 = aging disabled.
- age_confirmed  output  1  one-cycle response-valid pulse.
- age_ok  output  1  result, 1 = entry in date; valid only while age_confirmed=1.
- age_check_active  output  1  status; high whenever the FSM is not IDLE.

Behaviour:
- All outputs are registered. Reset values: age_confirmed=0, age_ok=0, age_check_active=0, FSM=IDLE, internal capture registers=0.
- FSM states: IDLE, CALC, CMP, RESP.
  - IDLE: on check_age=1, capture last_accessed, curr_time and max_age, then go to CALC.
  - CALC: age_r <= cap_time - cap_last, unsigned subtraction truncated to TIME_W (wrap-around is correct by construction). Go to CMP.
  - CMP: result_r <= (cap_max == 0) | (age_r <= cap_max), unsigned compare. Go to RESP.
  - RESP: age_confirmed=1 and age_ok=result_r for exactly this cycle. Return to IDLE.
- Latency: check_age sampled at edge N gives age_confirmed high in cycle N+3. Exactly one response per accepted request.
- check_age is ignored in CALC, CMP and RESP. A check_age seen in the same cycle as age_confirmed=1 is dropped, because it is the requester's stale re-pulse. A fresh request is accepted only in IDLE.
- age_ok is 0 whenever age_confirmed=0.
- max_age or curr_time changing mid-check has no effect, because the values captured at acceptance are used.
- Boundary values:
  - age == max_age gives ok.
  - age == max_age+1 gives stale.
  - last_accessed == curr_time gives age 0, ok.
  - last_accessed > curr_time gives the wrapped age, e.g. 0xFFFF_FFF0 → 0x10 is an age of 0x20.
- p_reset asserted mid-check: the FSM returns to IDLE at the next edge with no response. The requester is reset by the same signal.
- age_check_active = (state != IDLE), registered from next-state, so it is high in the three cycles CALC..RESP.

Optional Feature:
- Macro: ALUT_AGE_STATS_EN.
- With the macro defined, add the following ports:
  - stats_clr input 1.
  - chk_count output 16.
  - stale_count output 16.
- Counter behaviour:
  - chk_count increments on every RESP cycle.
  - stale_count increments on RESP with age_ok=0.
  - Both counters saturate at 0xFFFF.
  - stats_clr zeroes both counters, and takes priority over a simultaneous increment.
  - Both counters reset to 0.
- Without the macro: the ports and the logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Package alut_age_pkg holds:
  - TIME_W default;
  - FSM state encoding, 2-bit: IDLE=0, CALC=1, CMP=2, RESP=3;
  - AGE_DISABLED constant = 0.
- One sub-module, alut_age_stats, holds the saturating counter pair. It is instantiated only under ALUT_AGE_STATS_EN.

Test Plan:
- Reset, then check_age with last_accessed=0x100, curr_time=0x180, max_age=0x80 → age_confirmed at N+3, age_ok=1 (age == limit).
- Same request with curr_time=0x181 → age_ok=0; age_confirmed is a single-cycle pulse.
- last_accessed=0xFFFF_FFF0, curr_time=0x10, max_age=0x1F → age_ok=0; with max_age=0x20 → age_ok=1.
- max_age=0, last_accessed=0, curr_time=0xFFFF_FFFF → age_ok=1 (aging disabled).
- check_age pulsed in cycles N, N+2 and N+3 (N+3 coincides with age_confirmed) → exactly one response; age_check_active high in N+1..N+3. Also: change max_age at N+1 → no effect on the result.
- p_reset asserted at N+1 → no age_confirmed; all outputs 0. Under ALUT_AGE_STATS_EN: 3 checks with 1 stale → chk_count=3, stale_count=1; stats_clr → both 0.

Source files
------------

// File: rtl/alut_age_pkg.sv
// rtl/alut_age_pkg.sv - shared constants and FSM encoding for the ALUT age checker
package alut_age_pkg;

  localparam int TIME_W_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // A programmed maximum age of zero means aging is switched off.
  localparam int unsigned AGE_DISABLED = 0;

endpackage

// File: rtl/alut_age_stats.sv
// rtl/alut_age_stats.sv - saturating check/stale counters for the age checker (ALUT_AGE_STATS_EN)
module alut_age_stats (
  input  logic        pclk,
  input  logic        p_reset,
  input  logic        stats_clr,
  input  logic        inc_chk,
  input  logic        inc_stale,
  output logic [15:0] chk_count,
  output logic [15:0] stale_count
);

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge pclk) begin
    if (p_reset || stats_clr) begin
      chk_count   <= 16'h0000;
      stale_count <= 16'h0000;
    end else begin
      if (inc_chk && (chk_count != 16'hFFFF))
        chk_count <= chk_count + 16'h0001;
      if (inc_stale && (stale_count != 16'hFFFF))
        stale_count <= stale_count + 16'h0001;
    end
  end

endmodule

// File: rtl/alut_age_checker.sv
// rtl/alut_age_checker.sv - ALUT age-check responder; optional counters under ALUT_AGE_STATS_EN
module alut_age_checker
  import alut_age_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              pclk,
  input  logic              p_reset,
  input  logic              check_age,
  input  logic [TIME_W-1:0] last_accessed,
  input  logic [TIME_W-1:0] curr_time,
  input  logic [TIME_W-1:0] max_age,
`ifdef ALUT_AGE_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       chk_count,
  output logic [15:0]       stale_count,
`endif
  output logic              age_confirmed,
  output logic              age_ok,
  output logic              age_check_active
);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [TIME_W-1:0] cap_last;
  logic [TIME_W-1:0] cap_time;
  logic [TIME_W-1:0] cap_max;
  logic [TIME_W-1:0] age_r;
  logic              cmp_ok;

  // Requests arriving outside IDLE (including the re-pulse during RESP) are dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (check_age) next_state = ST_CALC;
      ST_CALC: next_state = ST_CMP;
      ST_CMP:  next_state = ST_RESP;
      default: next_state = ST_IDLE;
    endcase
  end

  assign cmp_ok = (cap_max == TIME_W'(AGE_DISABLED)) || (age_r <= cap_max);

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state            <= ST_IDLE;
      cap_last         <= '0;
      cap_time         <= '0;
      cap_max          <= '0;
      age_r            <= '0;
      age_confirmed    <= 1'b0;
      age_ok           <= 1'b0;
      age_check_active <= 1'b0;
    end else begin
      state            <= next_state;
      age_check_active <= (next_state != ST_IDLE);
      age_confirmed    <= (next_state == ST_RESP);
      age_ok           <= (next_state == ST_RESP) && cmp_ok;
      if ((state == ST_IDLE) && check_age) begin
        cap_last <= last_accessed;
        cap_time <= curr_time;
        cap_max  <= max_age;
      end
      // Modular subtraction gives the correct age across a timer wrap.
      if (state == ST_CALC)
        age_r <= cap_time - cap_last;
    end
  end

`ifdef ALUT_AGE_STATS_EN
  alut_age_stats u_stats (
    .pclk        (pclk),
    .p_reset     (p_reset),
    .stats_clr   (stats_clr),
    .inc_chk     (age_confirmed),
    .inc_stale   (age_confirmed && !age_ok),
    .chk_count   (chk_count),
    .stale_count (stale_count)
  );
`endif

endmodule

// File: tb/tb_alut_age_checker.sv
// tb/tb_alut_age_checker.sv - self-checking bench for alut_age_checker (ALUT_AGE_STATS_EN aware)
module tb_alut_age_checker;

  logic        pclk = 1'b0;
  logic        p_reset = 1'b1;
  logic        check_age = 1'b0;
  logic [31:0] last_accessed = '0;
  logic [31:0] curr_time = '0;
  logic [31:0] max_age = '0;
  logic        age_confirmed;
  logic        age_ok;
  logic        age_check_active;
`ifdef ALUT_AGE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] chk_count;
  logic [15:0] stale_count;
`endif

  int total  = 0;
  int passed = 0;
  int chk_model   = 0;
  int stale_model = 0;

  alut_age_checker #(.TIME_W(32)) dut (
    .pclk             (pclk),
    .p_reset          (p_reset),
    .check_age        (check_age),
    .last_accessed    (last_accessed),
    .curr_time        (curr_time),
    .max_age          (max_age),
`ifdef ALUT_AGE_STATS_EN
    .stats_clr        (stats_clr),
    .chk_count        (chk_count),
    .stale_count      (stale_count),
`endif
    .age_confirmed    (age_confirmed),
    .age_ok           (age_ok),
    .age_check_active (age_check_active)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Age is the elapsed time modulo 2^32; zero limit means never stale.
  function automatic logic model_ok(input logic [31:0] la, input logic [31:0] ct, input logic [31:0] mx);
    longint unsigned elapsed;
    elapsed = (64'(ct) + 64'h1_0000_0000 - 64'(la)) % 64'h1_0000_0000;
    return (mx == 0) || (elapsed <= 64'(mx));
  endfunction

  task automatic check_stats(input string tag);
`ifdef ALUT_AGE_STATS_EN
    chk({tag, ".chk_count"},   32'(chk_count),   32'(chk_model));
    chk({tag, ".stale_count"}, 32'(stale_count), 32'(stale_model));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One request accepted at edge N; inputs are scrambled afterwards and
  // optional re-pulses land in the CMP and RESP cycles.
  task automatic run_check(input string tag, input logic [31:0] la, input logic [31:0] ct,
                           input logic [31:0] mx, input bit repulse);
    logic exp_ok;
    exp_ok = model_ok(la, ct, mx);
    @(negedge pclk);
    check_age = 1'b1; last_accessed = la; curr_time = ct; max_age = mx;
    @(negedge pclk);
    check_age = 1'b0;
    last_accessed = $urandom; curr_time = $urandom; max_age = $urandom;
    chk({tag, ".n1_active"}, 32'(age_check_active), 32'd1);
    chk({tag, ".n1_conf"},   32'(age_confirmed),    32'd0);
    chk({tag, ".n1_ok"},     32'(age_ok),           32'd0);
    @(negedge pclk);
    check_age = repulse;
    chk({tag, ".n2_active"}, 32'(age_check_active), 32'd1);
    chk({tag, ".n2_conf"},   32'(age_confirmed),    32'd0);
    @(negedge pclk);
    check_age = repulse;
    chk({tag, ".n3_active"}, 32'(age_check_active), 32'd1);
    chk({tag, ".n3_conf"},   32'(age_confirmed),    32'd1);
    chk({tag, ".n3_ok"},     32'(age_ok),           32'(exp_ok));
    chk_model++;
    if (!exp_ok) stale_model++;
    @(negedge pclk);
    check_age = 1'b0;
    chk({tag, ".n4_active"}, 32'(age_check_active), 32'd0);
    chk({tag, ".n4_conf"},   32'(age_confirmed),    32'd0);
    chk({tag, ".n4_ok"},     32'(age_ok),           32'd0);
    check_stats(tag);
  endtask

  initial begin
    logic [31:0] la, mx, ct;
    int sel;
    repeat (3) @(negedge pclk);
    chk("rst.conf",   32'(age_confirmed),    32'd0);
    chk("rst.ok",     32'(age_ok),           32'd0);
    chk("rst.active", 32'(age_check_active), 32'd0);
    p_reset = 1'b0;
    chk_model = 0; stale_model = 0;
    check_stats("rst");

    run_check("eq_limit",   32'h100,       32'h180,       32'h80,        1'b0);
    run_check("over_limit", 32'h100,       32'h181,       32'h80,        1'b0);
    run_check("wrap_stale", 32'hFFFF_FFF0, 32'h10,        32'h1F,        1'b0);
    run_check("wrap_ok",    32'hFFFF_FFF0, 32'h10,        32'h20,        1'b0);
    run_check("disabled",   32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0);
    run_check("age_zero",   32'h1234_5678, 32'h1234_5678, 32'h1,         1'b0);
    run_check("repulse",    32'h100,       32'h181,       32'h81,        1'b1);

    for (int i = 0; i < 24; i++) begin
      la  = $urandom;
      mx  = $urandom_range(0, 32'h00FF_FFFF);
      sel = $urandom_range(0, 4);
      case (sel)
        0: ct = la + mx;
        1: ct = la + mx + 32'd1;
        2: ct = la + mx - 32'd1;
        3: begin mx = 32'd0; ct = $urandom; end
        default: ct = $urandom;
      endcase
      run_check($sformatf("rnd%0d", i), la, ct, mx, 1'($urandom_range(0, 1)));
    end

`ifdef ALUT_AGE_STATS_EN
    @(negedge pclk);
    stats_clr = 1'b1;
    @(negedge pclk);
    stats_clr = 1'b0;
    chk_model = 0; stale_model = 0;
    check_stats("clr");
    run_check("st_a", 32'h0,  32'h10, 32'h10, 1'b0);
    run_check("st_b", 32'h0,  32'h11, 32'h10, 1'b0);
    run_check("st_c", 32'h20, 32'h20, 32'h10, 1'b0);
    chk("stats3.chk",   32'(chk_count),   32'd3);
    chk("stats3.stale", 32'(stale_count), 32'd1);
    @(negedge pclk);
    stats_clr = 1'b1;
    @(negedge pclk);
    stats_clr = 1'b0;
    chk("clr2.chk",   32'(chk_count),   32'd0);
    chk("clr2.stale", 32'(stale_count), 32'd0);
    chk_model = 0; stale_model = 0;
`endif

    // Reset one cycle into a check must kill the response.
    @(negedge pclk);
    check_age = 1'b1; last_accessed = 32'h0; curr_time = 32'h5; max_age = 32'h10;
    @(negedge pclk);
    check_age = 1'b0;
    p_reset = 1'b1;
    @(negedge pclk);
    p_reset = 1'b0;
    chk_model = 0; stale_model = 0;
    chk("midrst.conf",   32'(age_confirmed),    32'd0);
    chk("midrst.ok",     32'(age_ok),           32'd0);
    chk("midrst.active", 32'(age_check_active), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk($sformatf("midrst.quiet%0d", i), 32'({age_confirmed, age_ok, age_check_active}), 32'd0);
    end
    check_stats("midrst");
    run_check("post_rst", 32'h40, 32'h50, 32'h10, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
